// File: rtl/systolic_add_ctrl.sv
// ============================================================================
// systolic_add_ctrl
// ----------------------------------------------------------------------------
// Control wrapper around an external multi-cycle FP16 adder in a systolic cell.
// It accepts one operand pair at a time and presents it to the adder on
// registered outputs. It then steps the adder's pipeline index for add_len
// cycles and captures the adder result into a register. That result is held
// until the downstream consumer takes it. The block does no arithmetic of its
// own: out_data is a bit-exact copy of add_output at the capture edge.
//
// Operation flow:
//   IDLE -> (in_valid)                  -> RUN  : operands registered, count=0
//   RUN  -> count steps 0..add_len-1    -> HOLD : result captured on last step
//   HOLD -> (out_ready & !in_valid)     -> IDLE
//   HOLD -> (out_ready &  in_valid)     -> RUN  : back-to-back, no bubble
//
// An operand pair accepted at edge E gives out_valid high from edge E+add_len.
//
// Parameters:
//   data_w   operand / result width (FP16 by default)
//   add_len  adder latency in cycles; must be at least 2
//
// Ports:
//   CLK         single clock, rising edge
//   RST         asynchronous, active-high reset
//   in_valid    operand pair offered
//   in_ready    block can accept an operand pair this cycle
//   in_a        first operand
//   in_b        second operand
//   add_start   one-cycle start strobe to the adder (first RUN cycle)
//   add_count   pipeline step index to the adder, 0..add_len-1
//   add_input1  registered operand A to the adder
//   add_input2  registered operand B to the adder
//   add_output  adder result, valid when add_count == add_len-1
//   out_valid   result available (HOLD only)
//   out_ready   downstream accepts the result
//   out_data    registered result
//   busy        high whenever the controller is not IDLE
// ============================================================================
module systolic_add_ctrl #(
    parameter int data_w  = 16,
    parameter int add_len = 3
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [data_w-1:0]          in_a,
    input  logic [data_w-1:0]          in_b,
    output logic                       add_start,
    output logic [$clog2(add_len)-1:0] add_count,
    output logic [data_w-1:0]          add_input1,
    output logic [data_w-1:0]          add_input2,
    input  logic [data_w-1:0]          add_output,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [data_w-1:0]          out_data,
    output logic                       busy
);

    localparam int cnt_w = $clog2(add_len);

    // Final pipeline step: the adder result is valid on add_output here.
    localparam logic [cnt_w-1:0] last_count = cnt_w'(add_len - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [cnt_w-1:0] count_next;
    logic             load_operands;   // accept in_a/in_b at this edge
    logic             capture_result;  // copy add_output into out_data at this edge

    // ------------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------------
    // NOTE: every signal written here gets a default before the case
    // statement, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_next     = state;
        count_next     = add_count;
        load_operands  = 1'b0;
        capture_result = 1'b0;
        in_ready       = 1'b0;
        add_start      = 1'b0;
        out_valid      = 1'b0;
        busy           = 1'b1;

        case (state)
            IDLE: begin
                in_ready   = 1'b1;
                busy       = 1'b0;
                count_next = '0;
                if (in_valid) begin
                    load_operands = 1'b1;
                    state_next    = RUN;
                end
            end

            RUN: begin
                // The adder starts on the first pipeline step only. in_valid is
                // not looked at here, so operands cannot be overwritten mid-op.
                add_start = (add_count == '0);
                if (add_count == last_count) begin
                    capture_result = 1'b1;
                    state_next     = HOLD;
                end else begin
                    count_next = add_count + cnt_w'(1);
                end
            end

            HOLD: begin
                // The result leaves when downstream takes it. A new pair may be
                // accepted on that same edge, which removes the idle cycle
                // between consecutive operations. add_count keeps its final
                // value while the result waits.
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    count_next = '0;
                    if (in_valid) begin
                        load_operands = 1'b1;
                        state_next    = RUN;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end

            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and pipeline-step registers
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            add_count <= '0;
        end else begin
            state     <= state_next;
            add_count <= count_next;
        end
    end

    // ------------------------------------------------------------------------
    // Operand and result registers
    // ------------------------------------------------------------------------
    // NOTE: these data registers are reset even though they carry no control
    // meaning. A reset mid-operation must leave the adder inputs and the
    // visible result at a known zero, not at the abandoned operation's values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            add_input1 <= '0;
            add_input2 <= '0;
            out_data   <= '0;
        end else begin
            if (load_operands) begin
                add_input1 <= in_a;
                add_input2 <= in_b;
            end
            if (capture_result) begin
                out_data <= add_output;
            end
        end
    end

endmodule

// File: tb/tb_systolic_add_ctrl.sv
// ============================================================================
// tb_systolic_add_ctrl
// ----------------------------------------------------------------------------
// Three controller instances run side by side with add_len = 3, 2 and 4
// (index 0, 1, 2). Each has its own stand-in adder. The stand-in latches the
// operands on add_start and drives its sum only while add_count == add_len-1.
// On any other step it drives the bit inverse of the sum, so a capture taken
// on the wrong step shows up as a corrupted result.
//
// The reference model is transaction-level. It records when an operand pair
// is accepted, counts the cycles since that acceptance, and derives every
// expected output from that age. Inputs change at posedge+1. Outputs are
// sampled at the following negedge.
// ============================================================================
module tb_systolic_add_ctrl;

    localparam int N = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid_v  [N];
    logic        out_ready_v [N];
    logic [15:0] in_a_v      [N];
    logic [15:0] in_b_v      [N];
    logic        in_ready_v  [N];
    logic        add_start_v [N];
    logic        out_valid_v [N];
    logic        busy_v      [N];
    logic [15:0] add_in1_v   [N];
    logic [15:0] add_in2_v   [N];
    logic [15:0] out_data_v  [N];
    int          cnt_v       [N];

    int n_vec = 0;
    int n_err = 0;

    function automatic int len_of(input int k);
        return (k == 0) ? 3 : ((k == 1) ? 2 : 4);
    endfunction

    // Stand-in adder function: exact FP16 sums for the directed operand
    // pairs, and an arbitrary but deterministic mix for random operands.
    function automatic logic [15:0] stub_sum(input logic [15:0] a, input logic [15:0] b);
        case ({a, b})
            {16'h3C00, 16'h4000}: return 16'h4200;   //  1 + 2 =  3
            {16'h4000, 16'h3C00}: return 16'h4200;
            {16'h3C00, 16'h3C00}: return 16'h4000;   //  1 + 1 =  2
            {16'h4000, 16'h4000}: return 16'h4400;   //  2 + 2 =  4
            {16'hC000, 16'h3C00}: return 16'hBC00;   // -2 + 1 = -1
            default:              return (a + b) ^ {b[7:0], a[15:8]};
        endcase
    endfunction

    for (genvar g = 0; g < N; g++) begin : inst
        localparam int L  = (g == 0) ? 3 : ((g == 1) ? 2 : 4);
        localparam int CW = $clog2(L);
        logic [CW-1:0] cnt;
        logic          in_ready_l, add_start_l, out_valid_l, busy_l;
        logic [15:0]   in1_l, in2_l, od_l, add_out, pend;

        systolic_add_ctrl #(.data_w(16), .add_len(L)) dut (
            .CLK       (clk),
            .RST       (rst),
            .in_valid  (in_valid_v[g]),
            .in_ready  (in_ready_l),
            .in_a      (in_a_v[g]),
            .in_b      (in_b_v[g]),
            .add_start (add_start_l),
            .add_count (cnt),
            .add_input1(in1_l),
            .add_input2(in2_l),
            .add_output(add_out),
            .out_valid (out_valid_l),
            .out_ready (out_ready_v[g]),
            .out_data  (od_l),
            .busy      (busy_l)
        );

        always @(posedge clk) if (add_start_l) pend <= stub_sum(in1_l, in2_l);
        assign add_out = (cnt == CW'(L - 1)) ? pend : ~pend;

        assign in_ready_v[g]  = in_ready_l;
        assign add_start_v[g] = add_start_l;
        assign out_valid_v[g] = out_valid_l;
        assign busy_v[g]      = busy_l;
        assign add_in1_v[g]   = in1_l;
        assign add_in2_v[g]   = in2_l;
        assign out_data_v[g]  = od_l;
        assign cnt_v[g]       = int'(cnt);
    end

    // ---------------- reference model ----------------
    bit          m_have [N];   // an operation is in flight or waiting
    int          m_age  [N];   // cycles since acceptance, saturating at add_len
    logic [15:0] m_a    [N];
    logic [15:0] m_b    [N];
    logic [15:0] m_res  [N];
    logic [15:0] m_od   [N];
    int          edge_n = 0;

    // Values observed on the most recent step, for scenario-level checks.
    bit          last_accept, obs_retire;
    logic        obs_start, obs_busy, obs_ov, obs_ready;
    int          obs_cnt, obs_edge;
    logic [15:0] obs_od, obs_in1, obs_in2;

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_have[k] = 0; m_age[k] = 0;
            m_a[k] = '0; m_b[k] = '0; m_res[k] = '0; m_od[k] = '0;
        end
    endtask

    task automatic drive(input int k, input logic v, input logic [15:0] a,
                         input logic [15:0] b, input logic ordy);
        in_valid_v[k] = v; in_a_v[k] = a; in_b_v[k] = b; out_ready_v[k] = ordy;
    endtask

    // One clock cycle on instance k: check all outputs against the model, then
    // advance the model across the next rising edge.
    task automatic step(input int k);
        int L, e_cnt;
        bit e_ready, e_busy, e_ov, e_start, acc, ret;
        L = len_of(k);
        @(negedge clk);
        if (!m_have[k]) begin
            e_ready = 1; e_busy = 0; e_ov = 0; e_cnt = 0; e_start = 0;
        end else if (m_age[k] < L) begin
            e_ready = 0; e_busy = 1; e_ov = 0; e_cnt = m_age[k]; e_start = (m_age[k] == 0);
        end else begin
            e_ready = out_ready_v[k]; e_busy = 1; e_ov = 1; e_cnt = L - 1; e_start = 0;
        end
        n_vec++; if (in_ready_v[k] !== e_ready) begin n_err++;
            $display("FAIL inst%0d in_ready @%0d: got %b want %b", k, edge_n, in_ready_v[k], e_ready); end
        n_vec++; if (busy_v[k] !== e_busy) begin n_err++;
            $display("FAIL inst%0d busy @%0d: got %b want %b", k, edge_n, busy_v[k], e_busy); end
        n_vec++; if (out_valid_v[k] !== e_ov) begin n_err++;
            $display("FAIL inst%0d out_valid @%0d: got %b want %b", k, edge_n, out_valid_v[k], e_ov); end
        n_vec++; if (add_start_v[k] !== e_start) begin n_err++;
            $display("FAIL inst%0d add_start @%0d: got %b want %b", k, edge_n, add_start_v[k], e_start); end
        n_vec++; if (cnt_v[k] != e_cnt) begin n_err++;
            $display("FAIL inst%0d add_count @%0d: got %0d want %0d", k, edge_n, cnt_v[k], e_cnt); end
        n_vec++; if (add_in1_v[k] !== m_a[k]) begin n_err++;
            $display("FAIL inst%0d add_input1 @%0d: got %h want %h", k, edge_n, add_in1_v[k], m_a[k]); end
        n_vec++; if (add_in2_v[k] !== m_b[k]) begin n_err++;
            $display("FAIL inst%0d add_input2 @%0d: got %h want %h", k, edge_n, add_in2_v[k], m_b[k]); end
        n_vec++; if (out_data_v[k] !== m_od[k]) begin n_err++;
            $display("FAIL inst%0d out_data @%0d: got %h want %h", k, edge_n, out_data_v[k], m_od[k]); end
        obs_start = add_start_v[k]; obs_busy = busy_v[k]; obs_ov = out_valid_v[k];
        obs_ready = in_ready_v[k]; obs_cnt = cnt_v[k]; obs_od = out_data_v[k];
        obs_in1 = add_in1_v[k]; obs_in2 = add_in2_v[k]; obs_edge = edge_n;
        acc = in_valid_v[k] && e_ready;
        ret = e_ov && out_ready_v[k];
        @(posedge clk);
        edge_n++;
        last_accept = acc;
        obs_retire  = ret;
        if (ret) m_have[k] = 0;
        if (acc) begin
            m_have[k] = 1; m_age[k] = 0;
            m_a[k] = in_a_v[k]; m_b[k] = in_b_v[k];
            m_res[k] = stub_sum(in_a_v[k], in_b_v[k]);
        end else if (m_have[k] && m_age[k] < L) begin
            m_age[k]++;
            if (m_age[k] == L) m_od[k] = m_res[k];
        end
        #1;
    endtask

    task automatic drain(input int k);
        drive(k, 1'b0, 16'h0, 16'h0, 1'b1);
        for (int i = 0; i < 12; i++) step(k);
        n_vec++; if (busy_v[k] !== 1'b0) begin n_err++;
            $display("FAIL inst%0d drain: busy got %b want 0", k, busy_v[k]); end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        for (int k = 0; k < N; k++) drive(k, 1'b0, 16'h0, 16'h0, 1'b1);
        #1 rst = 1'b1;
        #2;   // before the first rising edge: reset must act asynchronously
        for (int k = 0; k < N; k++) begin
            n_vec++; if (in_ready_v[k] !== 1'b1) begin n_err++; $display("FAIL reset inst%0d in_ready: got %b want 1", k, in_ready_v[k]); end
            n_vec++; if (busy_v[k] !== 1'b0) begin n_err++; $display("FAIL reset inst%0d busy: got %b want 0", k, busy_v[k]); end
            n_vec++; if (out_valid_v[k] !== 1'b0) begin n_err++; $display("FAIL reset inst%0d out_valid: got %b want 0", k, out_valid_v[k]); end
            n_vec++; if (add_start_v[k] !== 1'b0) begin n_err++; $display("FAIL reset inst%0d add_start: got %b want 0", k, add_start_v[k]); end
            n_vec++; if (cnt_v[k] != 0) begin n_err++; $display("FAIL reset inst%0d add_count: got %0d want 0", k, cnt_v[k]); end
            n_vec++; if (add_in1_v[k] !== 16'h0) begin n_err++; $display("FAIL reset inst%0d add_input1: got %h want 0000", k, add_in1_v[k]); end
            n_vec++; if (add_in2_v[k] !== 16'h0) begin n_err++; $display("FAIL reset inst%0d add_input2: got %h want 0000", k, add_in2_v[k]); end
            n_vec++; if (out_data_v[k] !== 16'h0) begin n_err++; $display("FAIL reset inst%0d out_data: got %h want 0000", k, out_data_v[k]); end
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_single(input int k, input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] want);
        int L, starts, ovs, first_ov, acc_e;
        int seq[$];
        logic [15:0] got;
        L = len_of(k); starts = 0; ovs = 0; first_ov = -1; got = 'x;
        drive(k, 1'b1, a, b, 1'b1);
        step(k);
        n_vec++; if (!last_accept) begin n_err++; $display("FAIL single inst%0d accept: got 0 want 1", k); end
        acc_e = edge_n;
        drive(k, 1'b0, 16'h0, 16'h0, 1'b1);
        for (int i = 0; i < L + 3; i++) begin
            step(k);
            if (obs_start === 1'b1) starts++;
            if (obs_busy === 1'b1 && obs_ov === 1'b0) seq.push_back(obs_cnt);
            if (obs_ov === 1'b1) begin
                ovs++;
                if (first_ov < 0) begin first_ov = obs_edge; got = obs_od; end
            end
        end
        n_vec++; if (starts != 1) begin n_err++; $display("FAIL single inst%0d add_start cycles: got %0d want 1", k, starts); end
        n_vec++; if (seq.size() != L) begin n_err++; $display("FAIL single inst%0d RUN cycles: got %0d want %0d", k, seq.size(), L); end
        for (int i = 0; i < seq.size(); i++) begin
            n_vec++; if (seq[i] != i) begin n_err++; $display("FAIL single inst%0d count seq[%0d]: got %0d want %0d", k, i, seq[i], i); end
        end
        n_vec++; if (ovs != 1) begin n_err++; $display("FAIL single inst%0d out_valid cycles: got %0d want 1", k, ovs); end
        n_vec++; if (first_ov - acc_e != L) begin n_err++; $display("FAIL single inst%0d latency: got %0d want %0d", k, first_ov - acc_e, L); end
        n_vec++; if (got !== want) begin n_err++; $display("FAIL single inst%0d result: got %h want %h", k, got, want); end
    endtask

    task automatic test_backpressure();
        int seen;
        drive(0, 1'b1, 16'h3C00, 16'h4000, 1'b0);
        step(0);
        drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
        seen = 0;
        for (int i = 0; i < 10 && seen == 0; i++) begin step(0); if (obs_ov === 1'b1) seen = 1; end
        n_vec++; if (seen == 0) begin n_err++; $display("FAIL backpressure out_valid: got 0 want 1 within 10 cycles"); end
        drive(0, 1'b1, 16'h3C00, 16'h3C00, 1'b0);   // second pair offered while stalled
        for (int i = 0; i < 5; i++) begin
            step(0);
            n_vec++; if (obs_ov !== 1'b1) begin n_err++; $display("FAIL backpressure hold%0d out_valid: got %b want 1", i, obs_ov); end
            n_vec++; if (obs_od !== 16'h4200) begin n_err++; $display("FAIL backpressure hold%0d out_data: got %h want 4200", i, obs_od); end
            n_vec++; if (obs_ready !== 1'b0) begin n_err++; $display("FAIL backpressure hold%0d in_ready: got %b want 0", i, obs_ready); end
        end
        out_ready_v[0] = 1'b1;
        step(0);
        n_vec++; if (!(last_accept && obs_retire)) begin n_err++;
            $display("FAIL backpressure release: accept/retire got %b/%b want 1/1", last_accept, obs_retire); end
        drain(0);
    endtask

    task automatic test_back_to_back();
        logic [15:0] pa[3] = '{16'h3C00, 16'h4000, 16'hC000};
        logic [15:0] pb[3] = '{16'h3C00, 16'h4000, 16'h3C00};
        logic [15:0] want[3] = '{16'h4000, 16'h4400, 16'hBC00};
        logic [15:0] res[$];
        int acc_e[3];
        int idx;
        idx = 0;
        drive(0, 1'b1, pa[0], pb[0], 1'b1);
        for (int i = 0; i < 30 && res.size() < 3; i++) begin
            step(0);
            if (obs_ov === 1'b1) res.push_back(obs_od);
            if (last_accept && idx < 3) begin
                acc_e[idx] = edge_n;
                idx++;
                if (idx < 3) drive(0, 1'b1, pa[idx], pb[idx], 1'b1);
                else         drive(0, 1'b0, 16'h0, 16'h0, 1'b1);
            end
        end
        n_vec++; if (res.size() != 3) begin n_err++; $display("FAIL b2b result count: got %0d want 3", res.size()); end
        for (int i = 0; i < res.size() && i < 3; i++) begin
            n_vec++; if (res[i] !== want[i]) begin n_err++; $display("FAIL b2b result%0d: got %h want %h", i, res[i], want[i]); end
        end
        if (idx == 3) begin
            for (int i = 1; i < 3; i++) begin
                n_vec++; if (acc_e[i] - acc_e[i-1] != 4) begin n_err++;
                    $display("FAIL b2b accept spacing%0d: got %0d want 4", i, acc_e[i] - acc_e[i-1]); end
            end
        end else begin
            n_vec++; n_err++; $display("FAIL b2b accepts: got %0d want 3", idx);
        end
        drain(0);
    endtask

    task automatic test_operand_stability();
        logic [15:0] a0, b0;
        a0 = 16'($urandom); b0 = 16'($urandom);
        drive(0, 1'b1, a0, b0, 1'b0);
        step(0);
        n_vec++; if (!last_accept) begin n_err++; $display("FAIL stability accept: got 0 want 1"); end
        for (int i = 0; i < 6; i++) begin
            drive(0, 1'b1, 16'($urandom), 16'($urandom), 1'b0);
            step(0);
            n_vec++; if (obs_in1 !== a0) begin n_err++; $display("FAIL stability cyc%0d add_input1: got %h want %h", i, obs_in1, a0); end
            n_vec++; if (obs_in2 !== b0) begin n_err++; $display("FAIL stability cyc%0d add_input2: got %h want %h", i, obs_in2, b0); end
        end
        drain(0);
    endtask

    task automatic test_reset_mid_op();
        drive(0, 1'b1, 16'h4000, 16'h4000, 1'b1);
        step(0);
        drive(0, 1'b0, 16'h0, 16'h0, 1'b1);
        step(0);   // returns with add_count == 1
        rst = 1'b1;
        #1;        // no clock edge in between
        n_vec++; if (busy_v[0] !== 1'b0) begin n_err++; $display("FAIL midreset busy: got %b want 0", busy_v[0]); end
        n_vec++; if (in_ready_v[0] !== 1'b1) begin n_err++; $display("FAIL midreset in_ready: got %b want 1", in_ready_v[0]); end
        n_vec++; if (cnt_v[0] != 0) begin n_err++; $display("FAIL midreset add_count: got %0d want 0", cnt_v[0]); end
        n_vec++; if (add_start_v[0] !== 1'b0) begin n_err++; $display("FAIL midreset add_start: got %b want 0", add_start_v[0]); end
        n_vec++; if (add_in1_v[0] !== 16'h0) begin n_err++; $display("FAIL midreset add_input1: got %h want 0000", add_in1_v[0]); end
        n_vec++; if (add_in2_v[0] !== 16'h0) begin n_err++; $display("FAIL midreset add_input2: got %h want 0000", add_in2_v[0]); end
        n_vec++; if (out_valid_v[0] !== 1'b0) begin n_err++; $display("FAIL midreset out_valid: got %b want 0", out_valid_v[0]); end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        drive(0, 1'b1, 16'hC000, 16'h3C00, 1'b1);
        step(0);
        n_vec++; if (!last_accept) begin n_err++; $display("FAIL midreset first handshake: got 0 want 1"); end
        drain(0);
        n_vec++; if (out_data_v[0] !== 16'hBC00) begin n_err++; $display("FAIL midreset new op result: got %h want BC00", out_data_v[0]); end
    endtask

    task automatic test_random(input int k, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            drive(k, 1'($urandom_range(0, 4) < 3), 16'($urandom), 16'($urandom),
                  1'($urandom_range(0, 4) < 3));
            step(k);
        end
        drain(k);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single(0, 16'h3C00, 16'h4000, 16'h4200);
        test_backpressure();
        test_back_to_back();
        test_operand_stability();
        test_reset_mid_op();
        test_single(1, 16'h3C00, 16'h4000, 16'h4200);
        test_single(2, 16'h4000, 16'h3C00, 16'h4200);
        test_random(0, 300);
        test_random(1, 200);
        test_random(2, 200);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
